// File: rtl/traffic_pkg.sv
// Shared state encoding, lamp constants and lamp decode for the intersection controller.
`default_nettype none

package traffic_pkg;

    typedef enum logic [2:0] {
        RED_TO_NS = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        RED_TO_EW = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        FLASH     = 3'd6
    } state_t;

    localparam logic [2:0] LIGHT_R   = 3'b100;
    localparam logic [2:0] LIGHT_Y   = 3'b010;
    localparam logic [2:0] LIGHT_G   = 3'b001;
    localparam logic [2:0] LIGHT_OFF = 3'b000;

    // Returns {ns_light, ew_light}; flash_off selects the dark half of night flash.
    function automatic logic [5:0] decode_lights(input state_t st, input logic flash_off);
        logic [5:0] l;
        l = {LIGHT_R, LIGHT_R};
        case (st)
            NS_GREEN:  l = {LIGHT_G, LIGHT_R};
            NS_YELLOW: l = {LIGHT_Y, LIGHT_R};
            EW_GREEN:  l = {LIGHT_R, LIGHT_G};
            EW_YELLOW: l = {LIGHT_R, LIGHT_Y};
            FLASH:     l = flash_off ? {LIGHT_OFF, LIGHT_OFF} : {LIGHT_Y, LIGHT_R};
            default:   l = {LIGHT_R, LIGHT_R};
        endcase
        return l;
    endfunction

    function automatic state_t ring_next(input state_t st);
        state_t n;
        case (st)
            RED_TO_NS: n = NS_GREEN;
            NS_GREEN:  n = NS_YELLOW;
            NS_YELLOW: n = RED_TO_EW;
            RED_TO_EW: n = EW_GREEN;
            EW_GREEN:  n = EW_YELLOW;
            default:   n = RED_TO_NS;
        endcase
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/phase_timer.sv
// Loadable down-counter that saturates at zero; load wins over count, hold freezes it.
`default_nettype none

module phase_timer #(
    parameter int             TW        = 6,
    parameter logic [TW-1:0]  RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hold,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          count,
    output logic          zero,
    output logic [TW-1:0] value
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= RESET_VAL;
        end else if (!hold) begin
            if (load) begin
                value <= load_val;
            end else if (count && (value != '0)) begin
                value <= value - 1'b1;
            end
        end
    end

    assign zero = (value == '0);

endmodule

`default_nettype wire

// File: rtl/traffic_phase_controller.sv
// Two-way intersection scheduler: phase ring, pedestrian extension, hold and night flash.
`default_nettype none

module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int G_TIME     = 27,
    parameter int Y_TIME     = 3,
    parameter int R_TIME     = 2,
    parameter int PED_EXT    = 10,
    parameter int FLASH_HALF = 8,
    parameter int TW         = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hold,
    input  logic          night,
    input  logic          ped_req_ns,
    input  logic          ped_req_ew,
    output logic [2:0]    ns_light,
    output logic [2:0]    ew_light,
    output logic          walk_ns,
    output logic          walk_ew,
    output logic [TW-1:0] remain,
    output logic [2:0]    phase
);

    localparam logic [TW-1:0] LOAD_G  = TW'(G_TIME - 1);
    localparam logic [TW-1:0] LOAD_GP = TW'(G_TIME + PED_EXT - 1);
    localparam logic [TW-1:0] LOAD_Y  = TW'(Y_TIME - 1);
    localparam logic [TW-1:0] LOAD_R  = TW'(R_TIME - 1);
    localparam logic [TW-1:0] LOAD_F  = TW'(FLASH_HALF - 1);

    state_t        state, state_n;
    logic          flash_off, flash_off_n;
    logic          latch_ns, latch_ns_n, latch_ew, latch_ew_n;
    logic          walk_ns_n, walk_ew_n;
    logic          load, zero;
    logic [TW-1:0] load_val;
    logic [5:0]    lights_n;

    // In FLASH the phase timer doubles as the half-period counter.
    phase_timer #(
        .TW        (TW),
        .RESET_VAL (LOAD_R)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .hold     (hold),
        .load     (load),
        .load_val (load_val),
        .count    (1'b1),
        .zero     (zero),
        .value    (remain)
    );

    always_comb begin
        state_n     = state;
        flash_off_n = flash_off;
        load        = 1'b0;
        load_val    = LOAD_R;
        latch_ns_n  = latch_ns | ped_req_ns;
        latch_ew_n  = latch_ew | ped_req_ew;
        walk_ns_n   = walk_ns;
        walk_ew_n   = walk_ew;

        if (!hold && zero) begin
            load = 1'b1;
            if (state == FLASH) begin
                if (night) begin
                    flash_off_n = ~flash_off;
                    load_val    = LOAD_F;
                end else begin
                    state_n     = RED_TO_NS;
                    flash_off_n = 1'b0;
                    load_val    = LOAD_R;
                end
            end else if (night) begin
                state_n     = FLASH;
                flash_off_n = 1'b0;
                load_val    = LOAD_F;
            end else begin
                state_n = ring_next(state);
                // A request arriving on the entry cycle is served now and not re-latched.
                case (state_n)
                    NS_GREEN: begin
                        load_val   = (latch_ns | ped_req_ns) ? LOAD_GP : LOAD_G;
                        walk_ns_n  = latch_ns | ped_req_ns;
                        latch_ns_n = 1'b0;
                    end
                    EW_GREEN: begin
                        load_val   = (latch_ew | ped_req_ew) ? LOAD_GP : LOAD_G;
                        walk_ew_n  = latch_ew | ped_req_ew;
                        latch_ew_n = 1'b0;
                    end
                    NS_YELLOW, EW_YELLOW: load_val = LOAD_Y;
                    default:              load_val = LOAD_R;
                endcase
            end
            if (state_n != NS_GREEN) walk_ns_n = 1'b0;
            if (state_n != EW_GREEN) walk_ew_n = 1'b0;
        end

        lights_n = decode_lights(state_n, flash_off_n);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RED_TO_NS;
            flash_off <= 1'b0;
            latch_ns  <= 1'b0;
            latch_ew  <= 1'b0;
            walk_ns   <= 1'b0;
            walk_ew   <= 1'b0;
            ns_light  <= LIGHT_R;
            ew_light  <= LIGHT_R;
        end else begin
            state     <= state_n;
            flash_off <= flash_off_n;
            latch_ns  <= latch_ns_n;
            latch_ew  <= latch_ew_n;
            walk_ns   <= walk_ns_n;
            walk_ew   <= walk_ew_n;
            ns_light  <= lights_n[5:3];
            ew_light  <= lights_n[2:0];
        end
    end

    assign phase = state;

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_controller.sv
// Scoreboard bench: directed scenarios queue per-cycle expectations; a negedge monitor checks them.
`default_nettype none

module tb_traffic_phase_controller;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] O = 3'b000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hold = 1'b0;
    logic       night = 1'b0;
    logic       ped_req_ns = 1'b0;
    logic       ped_req_ew = 1'b0;
    logic [2:0] ns_light, ew_light, phase;
    logic       walk_ns, walk_ew;
    logic [5:0] remain;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        int         cyc;
        logic [2:0] ns;
        logic [2:0] ew;
        logic       wns;
        logic       wew;
        int         rem;
        int         ph;
    } exp_t;

    exp_t sb[$];

    traffic_phase_controller dut (
        .clk        (clk),
        .reset      (reset),
        .hold       (hold),
        .night      (night),
        .ped_req_ns (ped_req_ns),
        .ped_req_ew (ped_req_ew),
        .ns_light   (ns_light),
        .ew_light   (ew_light),
        .walk_ns    (walk_ns),
        .walk_ew    (walk_ew),
        .remain     (remain),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    // cyc == k between edge k-1 and edge k; cycle 0 precedes the first edge after release.
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    task automatic check(input exp_t e);
        logic ok;
        checks++;
        ok = (ns_light == e.ns) && (ew_light == e.ew) && (walk_ns == e.wns) && (walk_ew == e.wew)
             && (e.rem < 0 || int'(remain) == e.rem) && (e.ph < 0 || int'(phase) == e.ph);
        if (!ok) begin
            errors++;
            $display("FAIL %s cyc=%0d: got ns=%b ew=%b walk=%b%b remain=%0d phase=%0d; want ns=%b ew=%b walk=%b%b remain=%0d phase=%0d",
                     e.name, e.cyc, ns_light, ew_light, walk_ns, walk_ew, remain, phase,
                     e.ns, e.ew, e.wns, e.wew, e.rem, e.ph);
        end
    endtask

    task automatic expect_at(input string nm, input int c, input logic [2:0] ns, input logic [2:0] ew,
                             input logic wns, input logic wew, input int rem, input int ph);
        exp_t e;
        e.name = nm; e.cyc = c; e.ns = ns; e.ew = ew;
        e.wns = wns; e.wew = wew; e.rem = rem; e.ph = ph;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL %s: cycle %0d never sampled (now %0d)", e.name, e.cyc, cyc);
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                check(e);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1; hold = 1'b0; night = 1'b0; ped_req_ns = 1'b0; ped_req_ew = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic end_test(input string nm, input int last);
        wait_cyc(last + 1);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expectations left unchecked, want 0", nm, sb.size());
            sb.delete();
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        exp_t e;

        // 1: free-running ring
        do_reset();
        expect_at("t1_reset",   0,  R, R, 0, 0, 1,  0);
        expect_at("t1_red1",    1,  R, R, 0, 0, 0,  0);
        expect_at("t1_nsg",     2,  G, R, 0, 0, 26, 1);
        expect_at("t1_nsg_end", 28, G, R, 0, 0, 0,  1);
        expect_at("t1_nsy",     29, Y, R, 0, 0, 2,  2);
        expect_at("t1_nsy_end", 31, Y, R, 0, 0, 0,  2);
        expect_at("t1_rew",     32, R, R, 0, 0, 1,  3);
        expect_at("t1_ewg",     34, R, G, 0, 0, 26, 4);
        expect_at("t1_ewg_end", 60, R, G, 0, 0, 0,  4);
        expect_at("t1_ewy",     61, R, Y, 0, 0, 2,  5);
        expect_at("t1_rns",     64, R, R, 0, 0, 1,  0);
        expect_at("t1_nsg2",    66, G, R, 0, 0, 26, 1);
        end_test("t1_drain", 66);

        // 2: EW pedestrian pulse extends the next EW green only
        do_reset();
        expect_at("t2_pre",     33,  R, R, 0, 0, 0,  3);
        expect_at("t2_ewg",     34,  R, G, 0, 1, 36, 4);
        expect_at("t2_ewg_end", 70,  R, G, 0, 1, 0,  4);
        expect_at("t2_ewy",     71,  R, Y, 0, 0, 2,  5);
        expect_at("t2_ewg2",    108, R, G, 0, 0, 26, 4);
        wait_cyc(10); ped_req_ew = 1'b1;
        wait_cyc(11); ped_req_ew = 1'b0;
        end_test("t2_drain", 108);

        // 3: hold freezes timer during NS green
        do_reset();
        expect_at("t3_pre",     20, G, R, 0, 0, 8, 1);
        expect_at("t3_frz_a",   22, G, R, 0, 0, 8, 1);
        expect_at("t3_frz_b",   25, G, R, 0, 0, 8, 1);
        expect_at("t3_resume",  26, G, R, 0, 0, 7, 1);
        expect_at("t3_nsg_end", 33, G, R, 0, 0, 0, 1);
        expect_at("t3_nsy",     34, Y, R, 0, 0, 2, 2);
        wait_cyc(20); hold = 1'b1;
        wait_cyc(25); hold = 1'b0;
        end_test("t3_drain", 34);

        // 4: night flash entered at green expiry, left at a half-period boundary
        do_reset();
        expect_at("t4_nsg_end", 28, G, R, 0, 0, 0,  1);
        expect_at("t4_on",      29, Y, R, 0, 0, 7,  6);
        expect_at("t4_on_end",  36, Y, R, 0, 0, 0,  6);
        expect_at("t4_off",     37, O, O, 0, 0, 7,  6);
        expect_at("t4_off_end", 44, O, O, 0, 0, 0,  6);
        expect_at("t4_rns",     45, R, R, 0, 0, 1,  0);
        expect_at("t4_nsg",     47, G, R, 0, 0, 26, 1);
        wait_cyc(15); night = 1'b1;
        wait_cyc(40); night = 1'b0;
        end_test("t4_drain", 47);

        // 5: asynchronous reset mid EW green clears walk and the pedestrian latch
        do_reset();
        expect_at("t5_walk", 39, R, G, 0, 1, 31, 4);
        wait_cyc(10); ped_req_ew = 1'b1;
        wait_cyc(11); ped_req_ew = 1'b0;
        wait_cyc(40);
        ped_req_ew = 1'b1;
        reset = 1'b1;
        #1;
        e.name = "t5_async_reset"; e.cyc = 40; e.ns = R; e.ew = R;
        e.wns = 1'b0; e.wew = 1'b0; e.rem = 1; e.ph = 0;
        check(e);
        ped_req_ew = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        expect_at("t5_ewg_plain", 34, R, G, 0, 0, 26, 4);
        end_test("t5_drain", 34);

        // 6: NS request on the RED_TO_NS expiry cycle is served immediately
        do_reset();
        expect_at("t6_nsg",     2,  G, R, 1, 0, 36, 1);
        expect_at("t6_nsg_end", 38, G, R, 1, 0, 0,  1);
        expect_at("t6_nsy",     39, Y, R, 0, 0, 2,  2);
        expect_at("t6_nsg2",    76, G, R, 0, 0, 26, 1);
        wait_cyc(1); ped_req_ns = 1'b1;
        wait_cyc(2); ped_req_ns = 1'b0;
        end_test("t6_drain", 76);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
